time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_pkg.sv | 12 +
 rtl/btn_edge_det.sv | 22 ++
 rtl/time_set_ctrl.sv | 106 ++++++++++
 tb/tb_time_set_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// time_set_pkg: shared FSM states, BCD digit widths and time limits for the time-set controller
package time_set_pkg;
  typedef enum logic [1:0] {IDLE, SET_HR, SET_MIN, COMMIT} state_t;
  localparam int MS_HR_W  = 2;
  localparam int LS_HR_W  = 4;
  localparam int MS_MIN_W = 3;
  localparam int LS_MIN_W = 4;
  localparam int HR_W     = MS_HR_W + LS_HR_W;
  localparam int MIN_W    = MS_MIN_W + LS_MIN_W;
  localparam logic [HR_W-1:0]  MAX_HR  = 6'h23;
  localparam logic [MIN_W-1:0] MAX_MIN = 7'h59;
endpackage

// File: rtl/btn_edge_det.sv
// btn_edge_det: registered rising-edge detector for a pre-synchronized button level
// Ports: clock, reset (sync, active-high); i_btn level in; o_press one cycle per rising edge.
module btn_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);
  logic r_btn_q;
  logic r_blk;
  // r_blk masks a button that is still held from reset until it has been released once
  always_ff @(posedge clock) begin
    if (reset) begin
      r_btn_q <= 1'b0;
      r_blk   <= i_btn;
    end else begin
      r_btn_q <= i_btn;
      r_blk   <= r_blk & i_btn;
    end
  end
  assign o_press = i_btn & ~r_btn_q & ~r_blk;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: two-button BCD time-set FSM that edits hours, then minutes, and commits with a one-cycle load
// Ports: clock, reset (sync, active-high); mode_btn/inc_btn button levels; cur_* running BCD time;
//        load strobe with load_* digits; editing, sel_hr, sel_min field indicators; blink display toggle.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BLINK_CYCLES   = 50
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode_btn,
  input  logic                inc_btn,
  input  logic [MS_HR_W-1:0]  cur_ms_hr,
  input  logic [LS_HR_W-1:0]  cur_ls_hr,
  input  logic [MS_MIN_W-1:0] cur_ms_min,
  input  logic [LS_MIN_W-1:0] cur_ls_min,
  output logic                load,
  output logic [MS_HR_W-1:0]  load_ms_hr,
  output logic [LS_HR_W-1:0]  load_ls_hr,
  output logic [MS_MIN_W-1:0] load_ms_min,
  output logic [LS_MIN_W-1:0] load_ls_min,
  output logic                editing,
  output logic                sel_hr,
  output logic                sel_min,
  output logic                blink
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;
  state_t r_state;
  state_t w_nxt;
  logic w_mode;
  logic w_inc;
  logic w_to;
  logic w_edit;
  logic [TW-1:0] r_to_cnt;
  logic [BW-1:0] r_bl_cnt;
  logic [MS_HR_W-1:0] r_ms_hr;
  logic [LS_HR_W-1:0] r_ls_hr;
  logic [MS_MIN_W-1:0] r_ms_min;
  logic [LS_MIN_W-1:0] r_ls_min;
  logic [HR_W-1:0] w_hr_inc;
  logic [MIN_W-1:0] w_min_inc;
  // out-of-range values and the top limit both wrap to zero
  function automatic logic [HR_W-1:0] hr_inc(input logic [HR_W-1:0] h);
    return (h[LS_HR_W-1:0] > 4'd9 || h >= MAX_HR) ? '0
         : h[LS_HR_W-1:0] == 4'd9 ? {h[HR_W-1:LS_HR_W] + 2'd1, 4'd0}
         : h + HR_W'(1);
  endfunction
  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
    return (m[LS_MIN_W-1:0] > 4'd9 || m >= MAX_MIN) ? '0
         : m[LS_MIN_W-1:0] == 4'd9 ? {m[MIN_W-1:LS_MIN_W] + 3'd1, 4'd0}
         : m + MIN_W'(1);
  endfunction
  btn_edge_det u_mode (.clock(clock), .reset(reset), .i_btn(mode_btn), .o_press(w_mode));
  btn_edge_det u_inc  (.clock(clock), .reset(reset), .i_btn(inc_btn),  .o_press(w_inc));
  assign w_hr_inc  = hr_inc({r_ms_hr, r_ls_hr});
  assign w_min_inc = min_inc({r_ms_min, r_ls_min});
  assign w_edit    = r_state == SET_HR || r_state == SET_MIN;
  // a press in the final cycle keeps the edit alive
  assign w_to      = r_to_cnt == TW'(TIMEOUT_CYCLES - 1) && !(w_mode || w_inc);
  always_comb begin
    w_nxt = r_state == COMMIT ? IDLE
          : w_mode ? (r_state == IDLE ? SET_HR : r_state == SET_HR ? SET_MIN : COMMIT)
          : (w_edit && w_to) ? IDLE
          : r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      load     <= 1'b0;
      {load_ms_hr, load_ls_hr, load_ms_min, load_ls_min} <= '0;
      {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= '0;
      r_to_cnt <= '0;
      r_bl_cnt <= '0;
      blink    <= 1'b0;
      editing  <= 1'b0;
      sel_hr   <= 1'b0;
      sel_min  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      sel_hr  <= w_nxt == SET_HR;
      sel_min <= w_nxt == SET_MIN;
      editing <= w_nxt == SET_HR || w_nxt == SET_MIN;
      load    <= w_nxt == COMMIT;
      if (w_nxt == COMMIT)
        {load_ms_hr, load_ls_hr, load_ms_min, load_ls_min} <= {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min};
      // mode outranks inc, so an inc arriving with mode never edits a field
      if (r_state == IDLE && w_mode)
        {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min} <= {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};
      else if (r_state == SET_HR && w_inc && !w_mode)
        {r_ms_hr, r_ls_hr} <= w_hr_inc;
      else if (r_state == SET_MIN && w_inc && !w_mode)
        {r_ms_min, r_ls_min} <= w_min_inc;
      r_to_cnt <= (!w_edit || w_nxt != r_state || w_mode || w_inc) ? '0 : r_to_cnt + TW'(1);
      if (w_nxt != r_state || !(w_nxt == SET_HR || w_nxt == SET_MIN)) begin
        r_bl_cnt <= '0;
        blink    <= 1'b0;
      end else if (r_bl_cnt == BW'(BLINK_CYCLES - 1)) begin
        r_bl_cnt <= '0;
        blink    <= ~blink;
      end else
        r_bl_cnt <= r_bl_cnt + BW'(1);
    end
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: randomized and directed checks of time_set_ctrl against a decimal time model
module tb_time_set_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic mode_btn = 1'b0;
  logic inc_btn = 1'b0;
  logic [1:0] cur_ms_hr = '0;
  logic [3:0] cur_ls_hr = '0;
  logic [2:0] cur_ms_min = '0;
  logic [3:0] cur_ls_min = '0;
  logic load;
  logic [1:0] load_ms_hr;
  logic [3:0] load_ls_hr;
  logic [2:0] load_ms_min;
  logic [3:0] load_ls_min;
  logic editing;
  logic sel_hr;
  logic sel_min;
  logic blink;
  int checks = 0;
  int errors = 0;
  int m_mh, m_lh, m_mm, m_lm;
  always #5 clock = ~clock;
  time_set_ctrl #(.TIMEOUT_CYCLES(16), .BLINK_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .cur_ms_hr(cur_ms_hr), .cur_ls_hr(cur_ls_hr), .cur_ms_min(cur_ms_min), .cur_ls_min(cur_ls_min),
    .load(load), .load_ms_hr(load_ms_hr), .load_ls_hr(load_ls_hr), .load_ms_min(load_ms_min),
    .load_ls_min(load_ls_min), .editing(editing), .sel_hr(sel_hr), .sel_min(sel_min), .blink(blink)
  );
  task automatic m_inc_hr();
    int v;
    v = m_mh * 10 + m_lh;
    v = (m_mh <= 2 && m_lh <= 9 && v <= 23) ? (v + 1) % 24 : 0;
    m_mh = v / 10;
    m_lh = v % 10;
  endtask
  task automatic m_inc_min();
    int v;
    v = m_mm * 10 + m_lm;
    v = (m_mm <= 5 && m_lm <= 9) ? (v + 1) % 60 : 0;
    m_mm = v / 10;
    m_lm = v % 10;
  endtask
  task automatic do_press(input logic m, input logic i, output logic l1, output logic [12:0] d1,
                          output logic l2, output logic [12:0] d2);
    mode_btn = m;
    inc_btn = i;
    @(negedge clock);
    l1 = load;
    d1 = {load_ms_hr, load_ls_hr, load_ms_min, load_ls_min};
    mode_btn = 1'b0;
    inc_btn = 1'b0;
    @(negedge clock);
    l2 = load;
    d2 = {load_ms_hr, load_ls_hr, load_ms_min, load_ls_min};
  endtask
  task automatic run_seq(input logic [12:0] cur, input int nh, input int nm, input bit simul,
                         output logic [12:0] got);
    logic l1, l2;
    logic [12:0] d1, d2, exp;
    {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = cur;
    m_mh = int'(cur[12:11]); m_lh = int'(cur[10:7]); m_mm = int'(cur[6:4]); m_lm = int'(cur[3:0]);
    do_press(1'b1, 1'b0, l1, d1, l2, d2);
    checks++;
    if ({editing, sel_hr, sel_min, l1, l2} !== 5'b11000) begin
      errors++;
      $display("FAIL enter_hr got ed/hr/min/ld=%b%b%b%b%b want 11000", editing, sel_hr, sel_min, l1, l2);
    end
    {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min} = 13'($urandom);
    repeat (nh) begin
      do_press(1'b0, 1'b1, l1, d1, l2, d2);
      m_inc_hr();
      checks++;
      if ({sel_hr, l1} !== 2'b10) begin
        errors++;
        $display("FAIL hr_inc got sel_hr=%b load=%b want 1 0", sel_hr, l1);
      end
    end
    do_press(1'b1, simul, l1, d1, l2, d2);
    checks++;
    if ({editing, sel_hr, sel_min, l1} !== 4'b1010) begin
      errors++;
      $display("FAIL enter_min got ed/hr/min/ld=%b%b%b%b want 1010", editing, sel_hr, sel_min, l1);
    end
    repeat (nm) begin
      do_press(1'b0, 1'b1, l1, d1, l2, d2);
      m_inc_min();
    end
    do_press(1'b1, 1'b0, l1, d1, l2, d2);
    exp = {m_mh[1:0], m_lh[3:0], m_mm[2:0], m_lm[3:0]};
    checks++;
    if (l1 !== 1'b1 || d1 !== exp) begin
      errors++;
      $display("FAIL commit got load=%b digits=%h want load=1 digits=%h", l1, d1, exp);
    end
    checks++;
    if (l2 !== 1'b0 || d2 !== exp || editing !== 1'b0) begin
      errors++;
      $display("FAIL after_commit got load=%b digits=%h editing=%b want 0 %h 0", l2, d2, editing, exp);
    end
    got = d1;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({load, load_ms_hr, load_ls_hr, load_ms_min, load_ls_min, editing, sel_hr, sel_min, blink} !== '0) begin
      errors++;
      $display("FAIL reset_state got load=%b digits=%h ed=%b blink=%b want all 0", load,
               {load_ms_hr, load_ls_hr, load_ms_min, load_ls_min}, editing, blink);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_idle_inc();
    logic l1, l2;
    logic [12:0] d1, d2;
    repeat (3) begin
      do_press(1'b0, 1'b1, l1, d1, l2, d2);
      checks++;
      if ({editing, l1, l2} !== 3'b000) begin
        errors++;
        $display("FAIL idle_inc got editing=%b load=%b%b want 0 00", editing, l1, l2);
      end
    end
  endtask
  task automatic test_directed();
    logic [12:0] got;
    run_seq({2'd1, 4'd2, 3'd3, 4'd4}, 3, 0, 1'b0, got);
    checks++;
    if (got !== {2'd1, 4'd5, 3'd3, 4'd4}) begin errors++; $display("FAIL d_1234 got %h want 15:34", got); end
    run_seq({2'd2, 4'd3, 3'd5, 4'd9}, 1, 1, 1'b0, got);
    checks++;
    if (got !== 13'd0) begin errors++; $display("FAIL d_2359 got %h want 00:00", got); end
    run_seq({2'd0, 4'd9, 3'd0, 4'd9}, 1, 0, 1'b0, got);
    checks++;
    if (got !== {2'd1, 4'd0, 3'd0, 4'd9}) begin errors++; $display("FAIL d_hr_carry got %h want 10:09", got); end
    run_seq({2'd0, 4'd9, 3'd0, 4'd9}, 0, 1, 1'b0, got);
    checks++;
    if (got !== {2'd0, 4'd9, 3'd1, 4'd0}) begin errors++; $display("FAIL d_min_carry got %h want 09:10", got); end
    run_seq({2'd2, 4'd7, 3'd1, 4'd5}, 1, 0, 1'b0, got);
    checks++;
    if (got !== {2'd0, 4'd0, 3'd1, 4'd5}) begin errors++; $display("FAIL d_bad_hr got %h want 00:15", got); end
    run_seq({2'd1, 4'd7, 3'd7, 4'd12}, 0, 1, 1'b0, got);
    checks++;
    if (got !== {2'd1, 4'd7, 3'd0, 4'd0}) begin errors++; $display("FAIL d_bad_min got %h want 17:00", got); end
    run_seq({2'd1, 4'd2, 3'd3, 4'd4}, 0, 0, 1'b1, got);
    checks++;
    if (got !== {2'd1, 4'd2, 3'd3, 4'd4}) begin errors++; $display("FAIL d_simul got %h want 12:34", got); end
  endtask
  task automatic test_timeout();
    int n_ed = 0;
    bit saw_load = 0;
    mode_btn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      mode_btn = 1'b0;
      if (load) saw_load = 1;
      if (editing) begin
        checks++;
        if (blink !== 1'(((n_ed / 4) % 2))) begin
          errors++;
          $display("FAIL blink cyc %0d got %b want %0d", n_ed, blink, (n_ed / 4) % 2);
        end
        n_ed++;
      end
    end
    checks++;
    if (n_ed != 16 || saw_load || blink !== 1'b0) begin
      errors++;
      $display("FAIL timeout got edit_cycles=%0d load_seen=%0d blink=%b want 16 0 0", n_ed, saw_load, blink);
    end
  endtask
  task automatic test_reset_in_min();
    logic l1, l2;
    logic [12:0] d1, d2;
    do_press(1'b1, 1'b0, l1, d1, l2, d2);
    do_press(1'b1, 1'b0, l1, d1, l2, d2);
    checks++;
    if (sel_min !== 1'b1) begin errors++; $display("FAIL rst_setup got sel_min=%b want 1", sel_min); end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({load, load_ms_hr, load_ls_hr, load_ms_min, load_ls_min, editing, sel_hr, sel_min, blink} !== '0) begin
      errors++;
      $display("FAIL rst_in_min got load=%b digits=%h ed=%b sel=%b%b want all 0", load,
               {load_ms_hr, load_ls_hr, load_ms_min, load_ls_min}, editing, sel_hr, sel_min);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({load, editing} !== 2'b00) begin errors++; $display("FAIL rst_after got load=%b ed=%b want 0 0", load, editing); end
  endtask
  task automatic test_reset_held();
    mode_btn = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (editing !== 1'b0) begin errors++; $display("FAIL held_btn got editing=%b want 0", editing); end
    end
    mode_btn = 1'b0;
    @(negedge clock);
    mode_btn = 1'b1;
    @(negedge clock);
    mode_btn = 1'b0;
    checks++;
    if (editing !== 1'b1) begin errors++; $display("FAIL repress got editing=%b want 1", editing); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask
  task automatic test_random();
    logic [12:0] cur, got;
    int h, mi;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) cur = 13'($urandom);
      else begin
        h = $urandom_range(0, 23);
        mi = $urandom_range(0, 59);
        cur = {2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10)};
      end
      run_seq(cur, $urandom_range(0, 25), $urandom_range(0, 62), 1'($urandom_range(0, 1)), got);
    end
  endtask
  initial begin
    test_reset();
    test_idle_inc();
    test_directed();
    test_timeout();
    test_reset_in_min();
    test_reset_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
